// File: rtl/alu_result_serial_tx.sv
// Buffers ALU results with derived Z/C/P flags in a small FIFO and streams them
// out as 13-bit UART-style frames (start, data[7:0], Z, C, P, stop), LSB first.
module alu_result_serial_tx #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned DEPTH        = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       res_valid,
  input  logic [7:0]                 res_data,
  input  logic [2:0]                 res_op,
  output logic                       res_ready,
  input  logic                       tx_en,
  input  logic                       clr_ovf,
  output logic                       tx_out,
  output logic                       tx_busy,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       ovf
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned TMR_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned ENTRY_W = 11;
  localparam int unsigned FRAME_W = 13;

  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    FLAGS = 3'd3,
    STOP  = 3'd4
  } state_t;

  state_t               state;
  logic [TMR_W-1:0]     timer;
  logic [2:0]           bit_idx;
  logic [FRAME_W-1:0]   shreg;

  logic [ENTRY_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;

  logic                 z_c;
  logic                 c_c;
  logic                 p_c;
  logic [ENTRY_W-1:0]   entry_c;
  logic                 push_c;
  logic                 pop_c;
  logic                 bit_end_c;
  logic [CNT_W-1:0]     count_nxt_c;
  logic [FRAME_W-1:0]   frame_c;

  // Flag derivation, handshake and pop decision
  always_comb begin
    z_c         = (res_data == 8'h00);
    c_c         = ((res_op == 3'b000) || (res_op == 3'b001)) && res_data[4];
    p_c         = ^res_data;
    entry_c     = {p_c, c_c, z_c, res_data};
    push_c      = res_valid && res_ready;
    bit_end_c   = (timer == '0);
    pop_c       = tx_en && (fifo_count != '0) &&
                  ((state == IDLE) || ((state == STOP) && bit_end_c));
    count_nxt_c = fifo_count + CNT_W'(push_c) - CNT_W'(pop_c);
    frame_c     = {1'b1, mem[rd_ptr], 1'b0};
  end

  // FIFO storage carries no reset; validity is tracked by the pointers and count
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= entry_c;
  end

  // FIFO pointers, occupancy, ready and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      res_ready  <= 1'b1;
      ovf        <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_count <= count_nxt_c;
      res_ready  <= (count_nxt_c != CNT_W'(DEPTH));
      if (res_valid && !res_ready) ovf <= 1'b1;
      else if (clr_ovf)            ovf <= 1'b0;
    end
  end

  // Transmit FSM: shreg[1] is always the next bit to drive at a bit boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '1;
      tx_out  <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop_c) begin
            state   <= START;
            timer   <= TMR_LOAD;
            bit_idx <= '0;
            shreg   <= frame_c;
            tx_out  <= frame_c[0];
            tx_busy <= 1'b1;
          end
        end
        START: begin
          if (bit_end_c) begin
            state   <= DATA;
            timer   <= TMR_LOAD;
            bit_idx <= '0;
            tx_out  <= shreg[1];
            shreg   <= {1'b1, shreg[FRAME_W-1:1]};
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        DATA, FLAGS: begin
          if (bit_end_c) begin
            timer  <= TMR_LOAD;
            tx_out <= shreg[1];
            shreg  <= {1'b1, shreg[FRAME_W-1:1]};
            if ((state == DATA) && (bit_idx == 3'd7)) begin
              state   <= FLAGS;
              bit_idx <= '0;
            end else if ((state == FLAGS) && (bit_idx == 3'd2)) begin
              state   <= STOP;
              bit_idx <= '0;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        STOP: begin
          if (bit_end_c) begin
            bit_idx <= '0;
            if (pop_c) begin
              state  <= START;
              timer  <= TMR_LOAD;
              shreg  <= frame_c;
              tx_out <= frame_c[0];
            end else begin
              state   <= IDLE;
              timer   <= '0;
              tx_busy <= 1'b0;
            end
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          timer   <= '0;
          bit_idx <= '0;
          tx_out  <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_serial_tx.sv
// Scoreboard bench: accepted results queue their expected frame; a line monitor
// receives frames off tx_out and compares them in order.
module tb_alu_result_serial_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned FLEN  = 13 * CPB;

  logic       clk;
  logic       rst_n;
  logic       res_valid;
  logic [7:0] res_data;
  logic [2:0] res_op;
  logic       res_ready;
  logic       tx_en;
  logic       clr_ovf;
  logic       tx_out;
  logic       tx_busy;
  logic [2:0] fifo_count;
  logic       ovf;

  alu_result_serial_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .res_valid(res_valid), .res_data(res_data),
    .res_op(res_op), .res_ready(res_ready), .tx_en(tx_en), .clr_ovf(clr_ovf),
    .tx_out(tx_out), .tx_busy(tx_busy), .fifo_count(fifo_count), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;
  logic [12:0] exp_q[$];
  int          frame_starts[$];

  // Reference frame built directly from the flag rules
  function automatic logic [12:0] make_frame(input logic [7:0] d, input logic [2:0] op);
    logic z, c, p;
    z = (d == 8'h00);
    c = (op == 3'd0 || op == 3'd1) ? d[4] : 1'b0;
    p = ^d;
    return {1'b1, p, c, z, d, 1'b0};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic offer(input logic [7:0] d, input logic [2:0] op, output bit acc);
    @(negedge clk);
    res_valid = 1'b1;
    res_data  = d;
    res_op    = op;
    acc       = res_ready;
    if (acc) exp_q.push_back(make_frame(d, op));
    @(posedge clk);
    #1;
    res_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0 && !tx_busy && fifo_count == 0) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain_timeout", int'(done), 1);
    #1;
  endtask

  // Line receiver: samples every cycle of the frame on the falling edge
  int          cyc;
  bit          in_frame;
  int          mon_cyc;
  logic [12:0] got;
  bit          frame_ok;

  initial begin
    cyc = 0; in_frame = 1'b0; mon_cyc = 0; got = '0; frame_ok = 1'b1;
  end

  always @(negedge clk) begin
    logic [12:0] exp_f;
    int b;
    cyc++;
    if (!rst_n) begin
      in_frame = 1'b0;
    end else begin
      if (!in_frame && tx_out == 1'b0) begin
        in_frame = 1'b1;
        mon_cyc  = 0;
        got      = '0;
        frame_ok = 1'b1;
        frame_starts.push_back(cyc);
      end
      if (in_frame) begin
        b = mon_cyc / CPB;
        if (mon_cyc % CPB == 0) got[b] = tx_out;
        else if (got[b] != tx_out) frame_ok = 1'b0;
        if (!tx_busy) frame_ok = 1'b0;
        mon_cyc++;
        if (mon_cyc == FLEN) begin
          in_frame = 1'b0;
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL frame_unexpected: got %03h expected none", got);
          end else begin
            exp_f = exp_q.pop_front();
            if (got != exp_f || !frame_ok) begin
              miscompares++;
              $display("FAIL frame: got %03h (stable/busy %0d) expected %03h", got, frame_ok, exp_f);
            end
          end
        end
      end
    end
  end

  initial begin
    bit acc;
    rst_n = 1'b0; res_valid = 1'b0; res_data = '0; res_op = '0;
    tx_en = 1'b0; clr_ovf = 1'b0;
    vectors = 0; miscompares = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_out", int'(tx_out), 1);
    chk("rst_busy", int'(tx_busy), 0);
    chk("rst_count", int'(fifo_count), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_ready", int'(res_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Single frame latency and 0x07 reference frame
    tx_en = 1'b1;
    offer(8'h07, 3'd0, acc);
    chk("lat_count_after_push", int'(fifo_count), 1);
    chk("lat_line_idle", int'(tx_out), 1);
    @(posedge clk);
    #1;
    chk("lat_start_bit", int'(tx_out), 0);
    chk("lat_busy", int'(tx_busy), 1);
    chk("lat_count_after_pop", int'(fifo_count), 0);
    wait_drain(200);

    // Flag corner cases
    offer(8'h10, 3'd1, acc);
    wait_drain(200);
    offer(8'h00, 3'd2, acc);
    wait_drain(200);
    offer(8'h10, 3'd5, acc);
    wait_drain(200);

    // Fill while transmit disabled, overflow, then back-to-back drain
    tx_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      offer(8'(8'h31 + 8'(i * 17)), 3'(i), acc);
      chk("fill_accept", int'(acc), (i < 4) ? 1 : 0);
    end
    chk("full_count", int'(fifo_count), 4);
    chk("full_ready", int'(res_ready), 0);
    chk("full_ovf", int'(ovf), 1);
    @(negedge clk);
    res_valid = 1'b1; res_data = 8'hEE; clr_ovf = 1'b1;
    @(posedge clk);
    #1;
    chk("ovf_set_beats_clr", int'(ovf), 1);
    res_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("ovf_cleared", int'(ovf), 0);
    clr_ovf = 1'b0;
    frame_starts.delete();
    tx_en = 1'b1;
    wait_drain(400);
    chk("b2b_frames", frame_starts.size(), 4);
    for (int i = 1; i < frame_starts.size(); i++)
      chk("b2b_gap", frame_starts[i] - frame_starts[i-1], FLEN);

    // Consecutive pushes while idle
    frame_starts.delete();
    offer(8'hA5, 3'd3, acc);
    offer(8'h3C, 3'd4, acc);
    wait_drain(300);
    chk("a5_3c_frames", frame_starts.size(), 2);
    if (frame_starts.size() == 2)
      chk("a5_3c_gap", frame_starts[1] - frame_starts[0], FLEN);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      offer(8'($urandom), 3'($urandom_range(0, 7)), acc);
      repeat ($urandom_range(0, 40)) @(posedge clk);
    end
    wait_drain(3000);
    @(negedge clk);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;

    // Reset mid-DATA with two entries queued
    offer(8'h5A, 3'd0, acc);
    offer(8'h81, 3'd1, acc);
    offer(8'hC3, 3'd6, acc);
    chk("pre_rst_count", int'(fifo_count), 2);
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_tx_out", int'(tx_out), 1);
    chk("mid_rst_count", int'(fifo_count), 0);
    chk("mid_rst_busy", int'(tx_busy), 0);
    @(negedge clk);
    #3;
    rst_n = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    chk("post_rst_line", int'(tx_out), 1);
    chk("post_rst_count", int'(fifo_count), 0);

    // Drop tx_en mid-frame
    offer(8'h96, 3'd0, acc);
    offer(8'h4B, 3'd2, acc);
    repeat (20) @(posedge clk);
    #1;
    tx_en = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    chk("txen_off_count", int'(fifo_count), 1);
    chk("txen_off_line", int'(tx_out), 1);
    chk("txen_off_busy", int'(tx_busy), 0);
    chk("txen_off_pending", exp_q.size(), 1);
    tx_en = 1'b1;
    wait_drain(200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
